usb_reg_responder: RTL and testbench

FPGA-side responder for the CW305 parallel USB register bus. It samples the host-driven address, data and strobe pins (usb_addr, usb_cen, usb_rdn, usb_wrn, usb_din) on usb_clk. Each chip-select assertion becomes exactly one single-cycle reg_write or reg_read strobe toward the register file. It returns read data on usb_dout with an output enable, and sits between the top-level USB pads and the trace/pattern register block.

---
 rtl/usb_reg_responder_if.sv | 28 ++
 rtl/usb_reg_responder.sv | 62 ++++++
 tb/tb_usb_reg_responder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/usb_reg_responder_if.sv
// usb_reg_responder_if: USB pad bus plus register-file side of the CW305 register responder.
interface usb_reg_responder_if #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7
);
  logic [7:0]                             usb_din;
  logic [7:0]                             usb_dout;
  logic                                   usb_isout;
  logic [pADDR_WIDTH-1:0]                 usb_addr;
  logic                                   usb_rdn;
  logic                                   usb_wrn;
  logic                                   usb_cen;
  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address;
  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt;
  logic [7:0]                             reg_datao;
  logic [7:0]                             reg_datai;
  logic                                   reg_write;
  logic                                   reg_read;
  logic                                   proto_err;
  modport slave (
    input  usb_din, usb_addr, usb_rdn, usb_wrn, usb_cen, reg_datai,
    output usb_dout, usb_isout, reg_address, reg_bytecnt, reg_datao, reg_write, reg_read, proto_err
  );
  modport master (
    output usb_din, usb_addr, usb_rdn, usb_wrn, usb_cen, reg_datai,
    input  usb_dout, usb_isout, reg_address, reg_bytecnt, reg_datao, reg_write, reg_read, proto_err
  );
endinterface

// File: rtl/usb_reg_responder.sv
// usb_reg_responder: turns each USB chip-select assertion into one registered reg_write/reg_read strobe.
module usb_reg_responder #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7
) (
  input logic                usb_clk,
  input logic                reset,
  usb_reg_responder_if.slave bus
);
  localparam logic [1:0] HOLD  = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] READ  = 2'd3;
  logic [pADDR_WIDTH-1:0] addr_q;
  logic [7:0]             din_q, rdata_q;
  logic                   rdn_q, wrn_q, cen_q;
  logic                   write_q, read_q, err_q;
  logic [1:0]             state_q, state_d;
  logic                   fire, write_d, read_d, err_d;
  always_comb begin
    fire    = state_q == IDLE && !cen_q;
    write_d = fire && !wrn_q;
    read_d  = fire && wrn_q && !rdn_q;
    err_d   = err_q || (write_d && !rdn_q);
    state_d = state_q == HOLD ? (cen_q ? IDLE : HOLD) :
              state_q == IDLE ? (cen_q ? IDLE : write_d ? WRITE : read_d ? READ : HOLD) :
              (cen_q ? IDLE : state_q);
  end
  // cen resets low so HOLD waits for a real deassertion before arming
  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      din_q   <= '0;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      cen_q   <= 1'b0;
      state_q <= HOLD;
      write_q <= 1'b0;
      read_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      addr_q  <= bus.usb_addr;
      din_q   <= bus.usb_din;
      rdn_q   <= bus.usb_rdn;
      wrn_q   <= bus.usb_wrn;
      cen_q   <= bus.usb_cen;
      state_q <= state_d;
      write_q <= write_d;
      read_q  <= read_d;
      err_q   <= err_d;
      if (!state_q[1]) rdata_q <= bus.reg_datai;
    end
  end
  assign {bus.reg_address, bus.reg_bytecnt} = addr_q;
  assign bus.reg_datao = din_q;
  assign bus.reg_write = write_q;
  assign bus.reg_read  = read_q;
  assign bus.proto_err = err_q;
  assign bus.usb_dout  = rdata_q;
  assign bus.usb_isout = ~rdn_q;
endmodule

// File: tb/tb_usb_reg_responder.sv
// tb_usb_reg_responder: host-side transactions against a loop-back register file and an expected-contents model.
module tb_usb_reg_responder;
  logic usb_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 usb_clk = ~usb_clk;
  usb_reg_responder_if bus ();
  usb_reg_responder dut (.usb_clk(usb_clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [13:0] a;
    logic [6:0]  b;
    logic [7:0]  d;
    int          c;
  } wr_t;
  wr_t        wq[$];
  int         rcnt  = 0;
  int         cyc   = 0;
  int         n_vec = 0;
  int         n_err = 0;
  bit         pre   = 1'b0;
  logic [7:0] mem[256];
  logic [7:0] exp_mem[256];
  function automatic logic [7:0] seed(int i);
    return i == 29 ? 8'h3C : 8'(i * 37 + 5);
  endfunction
  assign bus.reg_datai = mem[{bus.reg_address[5:0], bus.reg_bytecnt[1:0]}];
  always @(posedge usb_clk) cyc <= cyc + 1;
  always @(negedge usb_clk) begin
    if (!pre) begin
      for (int i = 0; i < 256; i++) mem[i] = seed(i);
      pre = 1'b1;
    end
    if (bus.reg_write) begin
      wq.push_back('{bus.reg_address, bus.reg_bytecnt, bus.reg_datao, cyc});
      mem[{bus.reg_address[5:0], bus.reg_bytecnt[1:0]}] = bus.reg_datao;
    end
    if (bus.reg_read) rcnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  // one host transaction; expectations come from exp_mem and the strobe rules
  task automatic xfer(input logic [13:0] a, input logic [6:0] b, input logic [7:0] d,
                      input logic rd, input logic wr, input int hold, output logic [7:0] q);
    int   t0, r0, idx;
    logic oe;
    wr_t  w;
    idx = {24'd0, a[5:0], b[1:0]};
    r0  = rcnt;
    bus.usb_addr = {a, b};
    bus.usb_din  = d;
    bus.usb_wrn  = ~wr;
    @(posedge usb_clk); #1;
    bus.usb_cen = 1'b0;
    bus.usb_rdn = ~rd;
    t0 = cyc;
    @(posedge usb_clk); #1;
    q  = bus.usb_dout;
    oe = bus.usb_isout;
    repeat (hold - 1) @(posedge usb_clk);
    #1;
    bus.usb_cen = 1'b1;
    bus.usb_rdn = 1'b1;
    bus.usb_wrn = 1'b1;
    @(posedge usb_clk); #1;
    chk("n_write", wq.size(), {31'd0, wr});
    chk("n_read", rcnt - r0, {31'd0, !wr && rd});
    if (wr && wq.size() != 0) begin
      w = wq.pop_front();
      chk("w_addr", w.a, a);
      chk("w_bcnt", w.b, b);
      chk("w_data", w.d, d);
      chk("w_lat", w.c - t0, 2);
      exp_mem[idx] = d;
    end
    wq.delete();
    if (rd && !wr) begin
      chk("r_data", q, exp_mem[idx]);
      chk("r_isout", oe, 1);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0]  q;
    logic [31:0] word;
    wr_t         w;
    for (int i = 0; i < 256; i++) exp_mem[i] = seed(i);
    bus.usb_addr = '0;
    bus.usb_din  = '0;
    bus.usb_cen  = 1'b1;
    bus.usb_rdn  = 1'b1;
    bus.usb_wrn  = 1'b1;
    repeat (3) @(posedge usb_clk);
    #1;
    chk("rst_write", bus.reg_write, 0);
    chk("rst_read", bus.reg_read, 0);
    chk("rst_err", bus.proto_err, 0);
    chk("rst_isout", bus.usb_isout, 0);
    chk("rst_dout", bus.usb_dout, 0);
    chk("rst_addr", {bus.reg_address, bus.reg_bytecnt}, 0);
    chk("rst_datao", bus.reg_datao, 0);
    reset = 1'b0;
    repeat (2) @(posedge usb_clk);
    #1;
    wq.delete();
    xfer(14'h05, 7'd2, 8'hA5, 1'b0, 1'b1, 2, q);
    chk("err_clean", bus.proto_err, 0);
    xfer(14'h07, 7'd1, 8'h00, 1'b1, 1'b0, 2, q);
    chk("read_3c", q, 8'h3C);
    // long chip select, then a second write after cen is high for one cycle
    bus.usb_addr = {14'h09, 7'd0};
    bus.usb_din  = 8'hC3;
    bus.usb_wrn  = 1'b0;
    @(posedge usb_clk); #1;
    bus.usb_cen = 1'b0;
    repeat (10) @(posedge usb_clk);
    #1;
    bus.usb_cen = 1'b1;
    @(posedge usb_clk); #1;
    bus.usb_din = 8'h11;
    bus.usb_cen = 1'b0;
    repeat (2) @(posedge usb_clk);
    #1;
    bus.usb_cen = 1'b1;
    bus.usb_wrn = 1'b1;
    @(posedge usb_clk); #1;
    chk("long_n", wq.size(), 2);
    if (wq.size() == 2) begin
      w = wq.pop_front();
      chk("long_d0", w.d, 8'hC3);
      w = wq.pop_front();
      chk("long_d1", w.d, 8'h11);
    end
    wq.delete();
    exp_mem[36] = 8'h11;
    xfer(14'h0A, 7'd3, 8'h5A, 1'b1, 1'b1, 2, q);
    chk("err_set", bus.proto_err, 1);
    xfer(14'h0B, 7'd0, 8'h01, 1'b0, 1'b1, 2, q);
    xfer(14'h0B, 7'd0, 8'h00, 1'b1, 1'b0, 3, q);
    xfer(14'h0C, 7'd1, 8'h02, 1'b0, 1'b1, 4, q);
    chk("err_sticky", bus.proto_err, 1);
    // reset in the middle of a write with cen held low
    bus.usb_addr = {14'h0D, 7'd2};
    bus.usb_din  = 8'h77;
    bus.usb_wrn  = 1'b0;
    @(posedge usb_clk); #1;
    bus.usb_cen = 1'b0;
    repeat (2) @(posedge usb_clk);
    #1;
    chk("pre_rst_w", bus.reg_write, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_w", bus.reg_write, 0);
    chk("rst_mid_err", bus.proto_err, 0);
    wq.delete();
    repeat (2) @(posedge usb_clk);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge usb_clk);
    #1;
    chk("rst_no_strobe", wq.size(), 0);
    bus.usb_cen = 1'b1;
    @(posedge usb_clk); #1;
    bus.usb_cen = 1'b0;
    repeat (2) @(posedge usb_clk);
    #1;
    bus.usb_cen = 1'b1;
    bus.usb_wrn = 1'b1;
    @(posedge usb_clk); #1;
    chk("rst_rearm_n", wq.size(), 1);
    if (wq.size() != 0) begin
      w = wq.pop_front();
      chk("rst_rearm_d", w.d, 8'h77);
    end
    wq.delete();
    exp_mem[54] = 8'h77;
    word = 32'h12345678;
    for (int i = 0; i < 4; i++) xfer(14'h30, 7'(i), word[8*i +: 8], 1'b0, 1'b1, 2, q);
    word = '0;
    for (int i = 0; i < 4; i++) begin
      xfer(14'h30, 7'(i), 8'h00, 1'b1, 1'b0, 2, q);
      word[8*i +: 8] = q;
    end
    chk("word", word, 32'h12345678);
    for (int n = 0; n < 40; n++) begin
      logic wr_op;
      wr_op = 1'($urandom_range(0, 1));
      xfer(14'($urandom_range(0, 63)), 7'($urandom_range(0, 3)), 8'($urandom),
           ~wr_op, wr_op, int'($urandom_range(2, 4)), q);
    end
    chk("final_err", bus.proto_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
